// File: rtl/f_npc_unit.sv
// Fetch-stage next-PC selection with an advisory return-address stack.
// F_pc follows a strict priority. The RAS only tracks jal/jr-ra pairs and never steers fetch.
module f_npc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter int          RAS_DEPTH  = 4,
  parameter int          ERET_PLUS4 = 1,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [31:0]      D_pc,
  input  logic [31:0]      immExt,
  input  logic [25:0]      instrIndex,
  input  logic [31:0]      regJr,
  input  logic             beq,
  input  logic             bne,
  input  logic             B_judge,
  input  logic             jal,
  input  logic             jr,
  input  logic             jr_ra,
  input  logic             Req,
  input  logic             eret,
  input  logic [31:0]      EPC,
  output logic [31:0]      F_pc,
  output logic             F_adel,
  output logic [31:0]      ras_top,
  output logic             ras_empty,
  output logic             ras_ovf,
  output logic             ras_unf,
  output logic [CNT_W-1:0] ras_hit_cnt
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

  logic [31:0]   ras_mem [RAS_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] top_idx;
  logic [PW:0]   ras_cnt;
  logic [31:0]   npc;
  logic [31:0]   eret_tgt;
  logic          br_taken;
  logic          ras_push;
  logic          ras_pop;
  logic          ras_full;

  assign br_taken = (beq | bne) & B_judge;
  assign eret_tgt = (ERET_PLUS4 != 0) ? EPC + 32'd4 : EPC;
  assign F_adel   = |F_pc[1:0];

  always_comb begin
    npc = F_pc + 32'd4;
    if (Req)           npc = EXC_VEC;
    else if (eret)     npc = eret_tgt;
    else if (stall)    npc = F_pc;
    else if (br_taken) npc = D_pc + 32'd4 + {immExt[29:0], 2'b00};
    else if (jal)      npc = {D_pc[31:28], instrIndex, 2'b00};
    else if (jr)       npc = regJr;
  end

  // wr_ptr names the next free slot; when full it also names the oldest entry.
  assign top_idx   = wr_ptr - {{(PW-1){1'b0}}, 1'b1};
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == DEPTH_C);
  assign ras_top   = ras_empty ? 32'd0 : ras_mem[top_idx];
  assign ras_push  = jal & ~stall & ~Req;
  assign ras_pop   = jr & jr_ra & ~jal & ~stall & ~Req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      F_pc <= RESET_PC;
    end else begin
      F_pc <= npc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= 32'd0;
      wr_ptr      <= '0;
      ras_cnt     <= '0;
      ras_ovf     <= 1'b0;
      ras_unf     <= 1'b0;
      ras_hit_cnt <= '0;
    end else if (ras_push) begin
      ras_mem[wr_ptr] <= D_pc + 32'd8;
      wr_ptr          <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      if (ras_full) ras_ovf <= 1'b1;
      else          ras_cnt <= ras_cnt + 1'b1;
    end else if (ras_pop) begin
      if (ras_empty) begin
        ras_unf <= 1'b1;
      end else begin
        wr_ptr  <= top_idx;
        ras_cnt <= ras_cnt - 1'b1;
        if (ras_top == regJr && ras_hit_cnt != '1) ras_hit_cnt <= ras_hit_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_f_npc_unit.sv
// Self-checking bench for f_npc_unit: directed scenarios, then random traffic vs. a queue-based model.
module tb_f_npc_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
  localparam int          DEPTH    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, beq, bne, B_judge, jal, jr, jr_ra, Req, eret;
  logic [31:0] D_pc, immExt, regJr, EPC;
  logic [25:0] instrIndex;
  logic [31:0] F_pc, ras_top;
  logic        F_adel, ras_empty, ras_ovf, ras_unf;
  logic [15:0] ras_hit_cnt;

  // reference model
  logic [31:0] m_pc;
  logic [31:0] ras_q[$];
  logic        m_ovf, m_unf;
  int unsigned m_hit;
  int n_cmp = 0;
  int n_err = 0;

  f_npc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .D_pc(D_pc), .immExt(immExt),
    .instrIndex(instrIndex), .regJr(regJr), .beq(beq), .bne(bne), .B_judge(B_judge),
    .jal(jal), .jr(jr), .jr_ra(jr_ra), .Req(Req), .eret(eret), .EPC(EPC),
    .F_pc(F_pc), .F_adel(F_adel), .ras_top(ras_top), .ras_empty(ras_empty),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf), .ras_hit_cnt(ras_hit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp_top;
    exp_top = (ras_q.size() == 0) ? 32'd0 : ras_q[ras_q.size()-1];
    chk({tag, ".F_pc"},    F_pc, m_pc);
    chk({tag, ".F_adel"},  {31'd0, F_adel}, {31'd0, (m_pc % 4) != 0});
    chk({tag, ".ras_top"}, ras_top, exp_top);
    chk({tag, ".empty"},   {31'd0, ras_empty}, {31'd0, ras_q.size() == 0});
    chk({tag, ".ovf"},     {31'd0, ras_ovf}, {31'd0, m_ovf});
    chk({tag, ".unf"},     {31'd0, ras_unf}, {31'd0, m_unf});
    chk({tag, ".hit"},     {16'd0, ras_hit_cnt}, m_hit);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC;
    ras_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_hit = 0;
  endtask

  // Next state from the current inputs, written straight from the priority rules.
  task automatic model_step();
    logic [31:0] nxt;
    if (Req)                        nxt = EXC_VEC;
    else if (eret)                  nxt = EPC + 4;
    else if (stall)                 nxt = m_pc;
    else if ((beq || bne) && B_judge) nxt = D_pc + 4 + immExt * 4;
    else if (jal)                   nxt = {D_pc[31:28], instrIndex, 2'b00};
    else if (jr)                    nxt = regJr;
    else                            nxt = m_pc + 4;
    if (!stall && !Req) begin
      if (jal) begin
        ras_q.push_back(D_pc + 8);
        if (ras_q.size() > DEPTH) begin
          void'(ras_q.pop_front());
          m_ovf = 1'b1;
        end
      end else if (jr && jr_ra) begin
        if (ras_q.size() == 0) m_unf = 1'b1;
        else begin
          if (ras_q[ras_q.size()-1] == regJr && m_hit < 65535) m_hit++;
          void'(ras_q.pop_back());
        end
      end
    end
    m_pc = nxt;
  endtask

  task automatic clear_in();
    {stall, beq, bne, B_judge, jal, jr, jr_ra, Req, eret} = '0;
    D_pc = 32'd0; immExt = 32'd0; regJr = 32'd0; EPC = 32'd0; instrIndex = 26'd0;
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] push_vals [4];
    push_vals[0] = 32'h3018; push_vals[1] = 32'h3014;
    push_vals[2] = 32'h3010; push_vals[3] = 32'h300C;
    clear_in();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    reset = 1'b1;

    // sequential fetch out of reset
    chk("seq0", F_pc, 32'h3000);
    for (int i = 1; i <= 3; i++) begin
      cycle("seq");
      chk("seq_pc", F_pc, 32'h3000 + 32'(4 * i));
    end

    // stalled branch holds, then redirects backwards
    D_pc = 32'h3010; beq = 1'b1; B_judge = 1'b1; immExt = 32'hFFFF_FFFC; stall = 1'b1;
    cycle("br_stall");
    chk("br_hold", F_pc, 32'h300C);
    stall = 1'b0;
    cycle("br_go");
    chk("br_tgt", F_pc, 32'h3004);
    clear_in();

    // Req beats eret/jal under stall, leaves RAS alone; then eret returns to EPC+4
    Req = 1'b1; eret = 1'b1; jal = 1'b1; stall = 1'b1; D_pc = 32'h3000;
    cycle("req");
    chk("req_pc", F_pc, 32'h4180);
    chk("req_ras", {31'd0, ras_empty}, 32'd1);
    clear_in();
    eret = 1'b1; EPC = 32'h3020;
    cycle("eret");
    chk("eret_pc", F_pc, 32'h3024);
    clear_in();

    // five calls overflow a four-deep stack, four matching returns drain it
    for (int i = 0; i < 5; i++) begin
      jal = 1'b1; D_pc = 32'h3000 + 32'(4 * i); instrIndex = 26'h0C40 + 26'(i);
      cycle("jal");
    end
    chk("ovf_flag", {31'd0, ras_ovf}, 32'd1);
    chk("ovf_top", ras_top, 32'h3018);
    clear_in();
    for (int i = 0; i < 4; i++) begin
      jr = 1'b1; jr_ra = 1'b1; regJr = push_vals[i];
      cycle("ret");
      chk("ret_pc", F_pc, push_vals[i]);
    end
    chk("hit4", {16'd0, ras_hit_cnt}, 32'd4);
    chk("drained", {31'd0, ras_empty}, 32'd1);

    // pop on empty stack
    jr = 1'b1; jr_ra = 1'b1; regJr = 32'h3100;
    cycle("unf");
    chk("unf_pc", F_pc, 32'h3100);
    chk("unf_flag", {31'd0, ras_unf}, 32'd1);
    chk("unf_hit", {16'd0, ras_hit_cnt}, 32'd4);
    clear_in();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      stall   = ($urandom_range(0, 5) == 0);
      Req     = ($urandom_range(0, 19) == 0);
      eret    = ($urandom_range(0, 14) == 0);
      beq     = ($urandom_range(0, 7) == 0);
      bne     = ($urandom_range(0, 7) == 0);
      B_judge = $urandom_range(0, 1);
      jal     = ($urandom_range(0, 3) == 0);
      jr      = ($urandom_range(0, 3) == 0);
      jr_ra   = jr & ($urandom_range(0, 3) != 0);
      D_pc    = $urandom & 32'hFFFF_FFFC;
      immExt  = 32'($signed($urandom_range(0, 255)) - 128);
      instrIndex = 26'($urandom);
      EPC     = $urandom & 32'hFFFF_FFFC;
      if (ras_q.size() != 0 && $urandom_range(0, 2) != 0) regJr = ras_q[ras_q.size()-1];
      else regJr = $urandom;
      cycle("rnd");
    end
    clear_in();

    // asynchronous reset mid-cycle
    jal = 1'b1; D_pc = 32'h3040;
    cycle("pre_rst");
    clear_in();
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_pc", F_pc, 32'h3000);
    @(posedge clk); #1;
    check_all("rst_hold");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cycle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
